// File: rtl/ti_psg_gen2.sv
// SN76489-class sound generator: three tone channels, one LFSR noise channel,
// log-volume mixer with stereo pan, write-busy handshake and PWM outputs.
module ti_psg_gen2 #(
  parameter int CLK_DIV  = 16,
  parameter int LFSR_W   = 16,
  parameter int LFSR_TAP = 3,
  parameter int PWM_W    = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       nCE,
  input  logic       nWE,
  input  logic       A0,
  input  logic [7:0] D,
  output logic       READY,
  output logic [9:0] MIX_L,
  output logic [9:0] MIX_R,
  output logic       AOUT_L,
  output logic       AOUT_R
);

  localparam int BW = $clog2(WAIT_CYC + 1);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [LFSR_W-1:0] SEED = {1'b1, {(LFSR_W-1){1'b0}}};

  logic [BW-1:0]     busy_q;
  logic [PW-1:0]     pre_q;
  logic [9:0]        per_q [3];
  logic [9:0]        cnt_q [3];
  logic [2:0]        tone_q;
  logic [3:0]        att_q [4];
  logic [2:0]        noise_q;
  logic [6:0]        ncnt_q;
  logic              ntog_q;
  logic              src_prev_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic [7:0]        pan_q;
  logic [1:0]        lch_q;
  logic              ltype_q;
  logic [9:0]        mix_l_q, mix_r_q;
  logic [PWM_W-1:0]  pwm_q, duty_l_q, duty_r_q;

  logic              wr_acc, wr_type, noise_wr, tick, src, fb;
  logic [1:0]        wr_ch;
  logic [6:0]        nper;
  logic [3:0]        chan;
  logic [9:0]        sum_l, sum_r;
  logic [PWM_W-1:0]  duty_l_eff, duty_r_eff;

  function automatic logic [7:0] amp(input logic [3:0] a);
    case (a)
      4'd0:  amp = 8'd255;
      4'd1:  amp = 8'd203;
      4'd2:  amp = 8'd161;
      4'd3:  amp = 8'd128;
      4'd4:  amp = 8'd102;
      4'd5:  amp = 8'd81;
      4'd6:  amp = 8'd64;
      4'd7:  amp = 8'd51;
      4'd8:  amp = 8'd40;
      4'd9:  amp = 8'd32;
      4'd10: amp = 8'd26;
      4'd11: amp = 8'd20;
      4'd12: amp = 8'd16;
      4'd13: amp = 8'd13;
      4'd14: amp = 8'd10;
      default: amp = 8'd0;
    endcase
  endfunction

  assign READY    = (busy_q == '0);
  assign wr_acc   = ~nCE & ~nWE & READY;
  // Data bytes reuse the channel/type captured by the last latch byte.
  assign wr_ch    = D[7] ? D[6:5] : lch_q;
  assign wr_type  = D[7] ? D[4] : ltype_q;
  assign noise_wr = wr_acc & ~A0 & ~wr_type & (wr_ch == 2'd3);
  assign tick     = (pre_q == PW'(CLK_DIV - 1));
  assign src      = (noise_q[1:0] == 2'b11) ? tone_q[2] : ntog_q;
  assign fb       = noise_q[2] ? (lfsr_q[0] ^ lfsr_q[LFSR_TAP]) : lfsr_q[0];
  assign chan     = {lfsr_q[0], tone_q};

  always_comb begin
    nper = 7'd64;
    case (noise_q[1:0])
      2'b00:   nper = 7'd16;
      2'b01:   nper = 7'd32;
      default: nper = 7'd64;
    endcase
  end

  // Busy counter: holds READY low for WAIT_CYC cycles after an accepted write.
  always_ff @(posedge CLK) begin
    if (RST)                busy_q <= '0;
    else if (wr_acc)        busy_q <= BW'(WAIT_CYC);
    else if (busy_q != '0)  busy_q <= busy_q - BW'(1);
  end

  // Register file: latch/data byte decode and stereo pan register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 3; i++) per_q[i] <= 10'h3FF;
      for (int i = 0; i < 4; i++) att_q[i] <= 4'hF;
      noise_q <= 3'd0;
      pan_q   <= 8'hFF;
      lch_q   <= 2'd0;
      ltype_q <= 1'b0;
    end else if (wr_acc) begin
      if (A0) begin
        pan_q <= D;
      end else begin
        if (D[7]) begin
          lch_q   <= D[6:5];
          ltype_q <= D[4];
        end
        if (wr_type)              att_q[wr_ch] <= D[3:0];
        else if (wr_ch == 2'd3)   noise_q <= D[2:0];
        else if (D[7])            per_q[wr_ch][3:0] <= D[3:0];
        else                      per_q[wr_ch][9:4] <= D[5:0];
      end
    end
  end

  // Prescaler: one channel tick every CLK_DIV clocks.
  always_ff @(posedge CLK) begin
    if (RST)       pre_q <= '0;
    else if (tick) pre_q <= '0;
    else           pre_q <= pre_q + PW'(1);
  end

  // Tone counters: reload with the current period (0 acts as 1) and toggle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= 10'd0;
      tone_q <= 3'b000;
    end else if (tick) begin
      for (int i = 0; i < 3; i++) begin
        if (cnt_q[i] <= 10'd1) begin
          cnt_q[i]  <= (per_q[i] == 10'd0) ? 10'd1 : per_q[i];
          tone_q[i] <= ~tone_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] - 10'd1;
        end
      end
    end
  end

  // Internal noise rate toggler, same reload rule as the tone counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ncnt_q <= 7'd0;
      ntog_q <= 1'b0;
    end else if (tick) begin
      if (ncnt_q <= 7'd1) begin
        ncnt_q <= nper;
        ntog_q <= ~ntog_q;
      end else begin
        ncnt_q <= ncnt_q - 7'd1;
      end
    end
  end

  // LFSR: seed reload on noise-control write wins over a rate-source shift.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr_q     <= SEED;
      src_prev_q <= 1'b0;
    end else begin
      src_prev_q <= src;
      if (noise_wr)              lfsr_q <= SEED;
      else if (src & ~src_prev_q) lfsr_q <= {fb, lfsr_q[LFSR_W-1:1]};
    end
  end

  // Per-side volume sum of enabled, currently-high channels.
  always_comb begin
    sum_l = 10'd0;
    sum_r = 10'd0;
    for (int i = 0; i < 4; i++) begin
      if (chan[i] && pan_q[4+i]) sum_l = sum_l + {2'b00, amp(att_q[i])};
      if (chan[i] && pan_q[i])   sum_r = sum_r + {2'b00, amp(att_q[i])};
    end
  end

  // Registered mix outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mix_l_q <= 10'd0;
      mix_r_q <= 10'd0;
    end else begin
      mix_l_q <= sum_l;
      mix_r_q <= sum_r;
    end
  end

  // PWM counter; duty is captured from the mix MSBs at the start of each frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_q    <= '0;
      duty_l_q <= '0;
      duty_r_q <= '0;
    end else begin
      pwm_q <= pwm_q + PWM_W'(1);
      if (pwm_q == '0) begin
        duty_l_q <= mix_l_q[9 -: PWM_W];
        duty_r_q <= mix_r_q[9 -: PWM_W];
      end
    end
  end

  // Count 0 compares against the freshly sampled duty so a frame is exact.
  assign duty_l_eff = (pwm_q == '0) ? mix_l_q[9 -: PWM_W] : duty_l_q;
  assign duty_r_eff = (pwm_q == '0) ? mix_r_q[9 -: PWM_W] : duty_r_q;
  assign AOUT_L     = (pwm_q < duty_l_eff);
  assign AOUT_R     = (pwm_q < duty_r_eff);
  assign MIX_L      = mix_l_q;
  assign MIX_R      = mix_r_q;

endmodule

// File: tb/tb_ti_psg_gen2.sv
module tb_ti_psg_gen2;
  localparam int CLK_DIV = 16, LFSR_W = 16, LFSR_TAP = 3, PWM_W = 8, WAIT_CYC = 2;

  logic CLK = 0, RST = 1, nCE = 1, nWE = 1, A0 = 0;
  logic [7:0] D = 8'h00;
  logic READY, AOUT_L, AOUT_R;
  logic [9:0] MIX_L, MIX_R;
  int checks = 0, failures = 0;

  ti_psg_gen2 #(.CLK_DIV(CLK_DIV), .LFSR_W(LFSR_W), .LFSR_TAP(LFSR_TAP),
                .PWM_W(PWM_W), .WAIT_CYC(WAIT_CYC)) dut (
    .CLK(CLK), .RST(RST), .nCE(nCE), .nWE(nWE), .A0(A0), .D(D),
    .READY(READY), .MIX_L(MIX_L), .MIX_R(MIX_R), .AOUT_L(AOUT_L), .AOUT_R(AOUT_R));

  always #5 CLK = ~CLK;

  // ---------------- behavioural reference model ----------------
  int amp_t[16] = '{255, 203, 161, 128, 102, 81, 64, 51, 40, 32, 26, 20, 16, 13, 10, 0};
  int m_pre, m_per[3], m_cnt[3], m_out[3], m_att[4], m_noise, m_ncnt, m_ntog, m_sprev;
  int m_lfsr, m_pan, m_lch, m_ltype, m_busy, m_mix_l, m_mix_r, m_pwm, m_duty_l, m_duty_r;

  task automatic model_step(input bit rst, input bit nce, input bit nwe, input bit a0,
                            input bit [7:0] d);
    int tick, sl, sr, src, shift, ch, ty, bitv, fb;
    if (rst) begin
      m_pre = 0; m_noise = 0; m_ncnt = 0; m_ntog = 0; m_sprev = 0;
      m_lfsr = 1 << (LFSR_W - 1); m_pan = 255; m_lch = 0; m_ltype = 0; m_busy = 0;
      m_mix_l = 0; m_mix_r = 0; m_pwm = 0; m_duty_l = 0; m_duty_r = 0;
      for (int i = 0; i < 3; i++) begin m_per[i] = 1023; m_cnt[i] = 0; m_out[i] = 0; end
      for (int i = 0; i < 4; i++) m_att[i] = 15;
      return;
    end
    tick = (m_pre == CLK_DIV - 1);
    m_pre = tick ? 0 : m_pre + 1;
    sl = 0; sr = 0;
    for (int i = 0; i < 4; i++) begin
      bitv = (i < 3) ? m_out[i] : (m_lfsr & 1);
      if (bitv != 0 && ((m_pan >> (4 + i)) & 1) != 0) sl += amp_t[m_att[i]];
      if (bitv != 0 && ((m_pan >> i) & 1) != 0)       sr += amp_t[m_att[i]];
    end
    if (m_pwm == 0) begin
      m_duty_l = m_mix_l >> (10 - PWM_W);
      m_duty_r = m_mix_r >> (10 - PWM_W);
    end
    m_pwm = (m_pwm + 1) % (1 << PWM_W);
    m_mix_l = sl; m_mix_r = sr;
    src = ((m_noise & 3) == 3) ? m_out[2] : m_ntog;
    shift = (src != 0 && m_sprev == 0);
    m_sprev = src;
    if (tick) begin
      for (int i = 0; i < 3; i++) begin
        if (m_cnt[i] <= 1) begin
          m_cnt[i] = (m_per[i] == 0) ? 1 : m_per[i];
          m_out[i] ^= 1;
        end else m_cnt[i]--;
      end
      if (m_ncnt <= 1) begin
        m_ncnt = 16 << (((m_noise & 3) == 3) ? 2 : (m_noise & 3));
        m_ntog ^= 1;
      end else m_ncnt--;
    end
    if (shift) begin
      fb = (m_noise & 4) ? ((m_lfsr ^ (m_lfsr >> LFSR_TAP)) & 1) : (m_lfsr & 1);
      m_lfsr = (m_lfsr >> 1) | (fb << (LFSR_W - 1));
    end
    if (!nce && !nwe && m_busy == 0) begin
      m_busy = WAIT_CYC;
      if (a0) m_pan = d;
      else begin
        ch = d[7] ? int'(d[6:5]) : m_lch;
        ty = d[7] ? int'(d[4])   : m_ltype;
        if (d[7]) begin m_lch = ch; m_ltype = ty; end
        if (ty == 1) m_att[ch] = d[3:0];
        else if (ch == 3) begin m_noise = d[2:0]; m_lfsr = 1 << (LFSR_W - 1); end
        else if (d[7]) m_per[ch] = (m_per[ch] & 'h3F0) | d[3:0];
        else           m_per[ch] = (m_per[ch] & 'h00F) | (int'(d[5:0]) << 4);
      end
    end else if (m_busy > 0) m_busy--;
  endtask

  always @(posedge CLK) model_step(RST, nCE, nWE, A0, D);

  function automatic logic [22:0] exp_vec();
    int dl, dr;
    dl = (m_pwm == 0) ? (m_mix_l >> (10 - PWM_W)) : m_duty_l;
    dr = (m_pwm == 0) ? (m_mix_r >> (10 - PWM_W)) : m_duty_r;
    return {(m_busy == 0), 10'(m_mix_l), 10'(m_mix_r), (m_pwm < dl), (m_pwm < dr)};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    RST = 1; nCE = 1; nWE = 1;
    repeat (2) @(negedge CLK);
    RST = 0;
  endtask

  task automatic wr(input bit a0, input bit [7:0] d);
    int n = 0;
    while (READY !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
    checks++;
    if (n >= 100) begin failures++; $display("FAIL wr_ready_timeout READY=%b want 1", READY); end
    A0 = a0; D = d; nCE = 0; nWE = 0;
    @(negedge CLK);
    nCE = 1; nWE = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (READY !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", READY); end
    checks++; if (MIX_L !== 10'd0) begin failures++; $display("FAIL reset_mix_l got=%0d want=0", MIX_L); end
    checks++; if (MIX_R !== 10'd0) begin failures++; $display("FAIL reset_mix_r got=%0d want=0", MIX_R); end
    checks++; if ({AOUT_L, AOUT_R} !== 2'b00) begin failures++; $display("FAIL reset_aout got=%b want=00", {AOUT_L, AOUT_R}); end
    for (int c = 0; c < 10000; c++) begin
      @(negedge CLK);
      checks++;
      if ({READY, MIX_L, MIX_R, AOUT_L, AOUT_R} !== exp_vec() || MIX_L !== 0 || MIX_R !== 0) begin
        failures++;
        $display("FAIL reset_silent cyc=%0d got=%h want=%h", c, {READY, MIX_L, MIX_R, AOUT_L, AOUT_R}, exp_vec());
      end
    end
  endtask

  task automatic test_tone();
    int last_t = -1, prev_t = -1;
    logic [9:0] pm;
    wr(0, 8'h8E); wr(0, 8'h0F); wr(0, 8'h90);
    pm = MIX_L;
    for (int c = 0; c < 20000; c++) begin
      @(negedge CLK);
      checks++;
      if ({READY, MIX_L, MIX_R, AOUT_L, AOUT_R} !== exp_vec() || !(MIX_L == 0 || MIX_L == 255)) begin
        failures++;
        $display("FAIL tone0 cyc=%0d got=%h want=%h", c, {READY, MIX_L, MIX_R, AOUT_L, AOUT_R}, exp_vec());
      end
      if (MIX_L !== pm) begin prev_t = last_t; last_t = c; pm = MIX_L; end
    end
    checks++;
    if (prev_t < 0 || last_t - prev_t != 254 * CLK_DIV) begin
      failures++; $display("FAIL tone0_interval got=%0d want=%0d", last_t - prev_t, 254 * CLK_DIV);
    end
  endtask

  task automatic test_busy();
    int lows = 0;
    do_reset();
    A0 = 0; D = 8'h8E; nCE = 0; nWE = 0;
    @(negedge CLK);
    checks++; if (READY !== 1'b0) begin failures++; $display("FAIL busy_low1 got=%b want=0", READY); end
    D = 8'h0F;
    @(negedge CLK);
    checks++; if (READY !== 1'b0) begin failures++; $display("FAIL busy_low2 got=%b want=0", READY); end
    nCE = 1; nWE = 1;
    @(negedge CLK);
    checks++; if (READY !== 1'b1) begin failures++; $display("FAIL busy_release got=%b want=1", READY); end
    // held strobe: re-accepted every WAIT_CYC+1 cycles
    A0 = 1; D = 8'hFF; nCE = 0; nWE = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge CLK);
      if (READY === 1'b0) lows++;
      checks++;
      if ({READY, MIX_L, MIX_R, AOUT_L, AOUT_R} !== exp_vec()) begin
        failures++;
        $display("FAIL busy_held cyc=%0d got=%h want=%h", c, {READY, MIX_L, MIX_R, AOUT_L, AOUT_R}, exp_vec());
      end
    end
    nCE = 1; nWE = 1;
    checks++; if (lows != 6) begin failures++; $display("FAIL busy_held_lows got=%0d want=6", lows); end
  endtask

  task automatic test_noise();
    int seen_hi = 0;
    do_reset();
    wr(0, 8'hE4); wr(0, 8'hF0);
    for (int c = 0; c < 20000; c++) begin
      @(negedge CLK);
      checks++;
      if ({READY, MIX_L, MIX_R, AOUT_L, AOUT_R} !== exp_vec() || (c < 7000 && MIX_L !== 0)) begin
        failures++;
        $display("FAIL noise cyc=%0d got=%h want=%h", c, {READY, MIX_L, MIX_R, AOUT_L, AOUT_R}, exp_vec());
      end
      if (MIX_L === 10'd255) seen_hi++;
    end
    checks++; if (seen_hi == 0) begin failures++; $display("FAIL noise_active got=0 want=>0 high cycles"); end
  endtask

  task automatic test_pan();
    int hi_l, hi_r;
    do_reset();
    wr(0, 8'h81); wr(0, 8'h00); wr(0, 8'h90);
    repeat (50) @(negedge CLK);
    for (int side = 0; side < 2; side++) begin
      wr(1, side == 0 ? 8'h0F : 8'hF0);
      hi_l = 0; hi_r = 0;
      for (int c = 0; c < 400; c++) begin
        @(negedge CLK);
        checks++;
        if ({READY, MIX_L, MIX_R, AOUT_L, AOUT_R} !== exp_vec() ||
            (side == 0 && MIX_L !== 0) || (side == 1 && MIX_R !== 0)) begin
          failures++;
          $display("FAIL pan side=%0d cyc=%0d got=%h want=%h", side, c, {READY, MIX_L, MIX_R, AOUT_L, AOUT_R}, exp_vec());
        end
        if (MIX_L === 10'd255) hi_l++;
        if (MIX_R === 10'd255) hi_r++;
      end
      checks++;
      if ((side == 0 ? hi_r : hi_l) == 0) begin
        failures++; $display("FAIL pan_toggle side=%0d got=0 want=>0 high cycles", side);
      end
    end
  endtask

  task automatic test_mid_reset();
    int hi_l = 0, hi_r = 0;
    wr(1, 8'hFF);
    repeat (40) @(negedge CLK);
    RST = 1; A0 = 1; D = 8'h00; nCE = 0; nWE = 0;
    @(negedge CLK);
    RST = 0; nCE = 1; nWE = 1;
    checks++;
    if ({READY, MIX_L, MIX_R, AOUT_L, AOUT_R} !== {1'b1, 22'd0}) begin
      failures++; $display("FAIL midrst_state got=%h want=%h", {READY, MIX_L, MIX_R, AOUT_L, AOUT_R}, {1'b1, 22'd0});
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge CLK);
      checks++;
      if ({READY, MIX_L, MIX_R, AOUT_L, AOUT_R} !== exp_vec() || MIX_L !== 0 || MIX_R !== 0) begin
        failures++; $display("FAIL midrst_silent cyc=%0d got=%h want=%h", c, {READY, MIX_L, MIX_R, AOUT_L, AOUT_R}, exp_vec());
      end
    end
    wr(0, 8'h90);
    for (int c = 0; c < 300; c++) begin
      @(negedge CLK);
      checks++;
      if ({READY, MIX_L, MIX_R, AOUT_L, AOUT_R} !== exp_vec()) begin
        failures++; $display("FAIL midrst_after cyc=%0d got=%h want=%h", c, {READY, MIX_L, MIX_R, AOUT_L, AOUT_R}, exp_vec());
      end
      if (MIX_L === 10'd255) hi_l++;
      if (MIX_R === 10'd255) hi_r++;
    end
    checks++;
    if (hi_l == 0 || hi_r == 0) begin
      failures++; $display("FAIL midrst_pan_kept got=%0d/%0d want=>0 both", hi_l, hi_r);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    int gap;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 200);
      for (int c = 0; c < gap; c++) begin
        @(negedge CLK);
        checks++;
        if ({READY, MIX_L, MIX_R, AOUT_L, AOUT_R} !== exp_vec()) begin
          failures++; $display("FAIL random n=%0d cyc=%0d got=%h want=%h", n, c, {READY, MIX_L, MIX_R, AOUT_L, AOUT_R}, exp_vec());
        end
      end
      d = 8'($urandom);
      if (!d[7] && $urandom_range(0, 1) == 1) d[5:0] = 6'd0;
      wr(($urandom_range(0, 7) == 0), d);
    end
  endtask

  initial begin
    test_reset();
    test_tone();
    test_busy();
    test_noise();
    test_pan();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
